apu_req_queue: RTL and testbench

Request buffer between the core's APU interface and `vector_decoder`. Accepts offloaded vector instructions (operands, op, flags) from the core into a small in-order FIFO. The core can therefore issue back-to-back requests while the decoder is busy with multi-cycle instructions. It presents the queue head to the decoder using the same req/gnt handshake, and tracks in-flight instructions so the core and system can tell when the accelerator is idle.

---
 rtl/accelerator_pkg.sv | 19 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/apu_req_queue.sv | 96 +++++++++
 tb/tb_apu_req_queue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/accelerator_pkg.sv
// accelerator_pkg: definitions shared between the APU request queue and the vector decoder.
`default_nettype none

package accelerator_pkg;

    localparam int APU_OP_W       = 6;
    localparam int APU_FLAGS_W    = 15;
    localparam int APU_NUM_OPERANDS = 3;

    // operands[2] carries the offloaded instruction word
    typedef struct packed {
        logic [APU_NUM_OPERANDS-1:0][31:0] operands;
        logic [APU_OP_W-1:0]               op;
        logic [APU_FLAGS_W-1:0]            flags;
    } apu_req_entry_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo: in-order FIFO with registered head, wrapping pointers and an occupancy count.
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/apu_req_queue.sv
// apu_req_queue: buffers offloaded APU requests for the vector decoder and tracks
// instructions accepted but not yet completed.
`default_nettype none

module apu_req_queue
    import accelerator_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                            clk,
    input  logic                            n_reset,
    input  logic                            core_apu_req,
    output logic                            core_apu_gnt,
    input  logic [31:0]                     core_apu_operands [2:0],
    input  logic [APU_OP_W-1:0]             core_apu_op,
    input  logic [APU_FLAGS_W-1:0]          core_apu_flags_i,
    output logic                            core_apu_rvalid,
    output logic                            dec_apu_req,
    input  logic                            dec_apu_gnt,
    output logic [31:0]                     dec_apu_operands [2:0],
    output logic [APU_OP_W-1:0]             dec_apu_op,
    output logic [APU_FLAGS_W-1:0]          dec_apu_flags_i,
    input  logic                            dec_apu_rvalid,
    output logic [$clog2(DEPTH):0]          queue_count,
    output logic [$clog2(MAX_INFLIGHT):0]   inflight_count,
    output logic                            idle
);

    localparam int IW = $clog2(MAX_INFLIGHT) + 1;

    apu_req_entry_t wr_entry;
    apu_req_entry_t head;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    always_comb begin
        wr_entry.op    = core_apu_op;
        wr_entry.flags = core_apu_flags_i;
        for (int i = 0; i < APU_NUM_OPERANDS; i++) begin
            wr_entry.operands[i] = core_apu_operands[i];
        end
    end

    always_comb begin
        dec_apu_op      = head.op;
        dec_apu_flags_i = head.flags;
        for (int i = 0; i < APU_NUM_OPERANDS; i++) begin
            dec_apu_operands[i] = head.operands[i];
        end
    end

    // Grant looks only at registered state so the core never sees a req->gnt loop
    assign core_apu_gnt    = !full && (inflight_count < IW'(MAX_INFLIGHT));
    assign push            = core_apu_req && core_apu_gnt;
    assign dec_apu_req     = !empty;
    assign pop             = dec_apu_req && dec_apu_gnt;
    assign core_apu_rvalid = dec_apu_rvalid;
    assign idle            = (inflight_count == '0);

    sync_fifo #(
        .WIDTH ($bits(apu_req_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (push),
        .pop     (pop),
        .wdata   (wr_entry),
        .rdata   (head),
        .count   (queue_count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            inflight_count <= '0;
        end else begin
            case ({push, dec_apu_rvalid})
                2'b10:   inflight_count <= inflight_count + 1'b1;
                // a stray completion at zero is a protocol error; hold at zero
                2'b01:   if (inflight_count != '0) inflight_count <= inflight_count - 1'b1;
                default: inflight_count <= inflight_count;
            endcase
        end
    end

    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!n_reset)
        !(dec_apu_rvalid && (inflight_count == '0)));

endmodule

`default_nettype wire

// File: tb/tb_apu_req_queue.sv
// tb_apu_req_queue: directed and random stimulus against a queue-based reference model.
`default_nettype none

module tb_apu_req_queue;
    import accelerator_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXI  = 8;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    // main DUT (DEPTH 4, MAX_INFLIGHT 8)
    logic        core_req = 1'b0, dec_gnt = 1'b0, dec_rvalid = 1'b0;
    logic [31:0] core_ops [2:0];
    logic [5:0]  core_op = '0;
    logic [14:0] core_flags = '0;
    logic        core_gnt, core_rvalid, dec_req, idle;
    logic [31:0] dec_ops [2:0];
    logic [5:0]  dec_op;
    logic [14:0] dec_flags;
    logic [2:0]  qcount;
    logic [3:0]  icount;

    apu_req_queue #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)) u_dut (
        .clk(clk), .n_reset(n_reset),
        .core_apu_req(core_req), .core_apu_gnt(core_gnt),
        .core_apu_operands(core_ops), .core_apu_op(core_op), .core_apu_flags_i(core_flags),
        .core_apu_rvalid(core_rvalid),
        .dec_apu_req(dec_req), .dec_apu_gnt(dec_gnt),
        .dec_apu_operands(dec_ops), .dec_apu_op(dec_op), .dec_apu_flags_i(dec_flags),
        .dec_apu_rvalid(dec_rvalid),
        .queue_count(qcount), .inflight_count(icount), .idle(idle)
    );

    // second DUT with MAX_INFLIGHT 4
    logic        b_req = 1'b0, b_dgnt = 1'b0, b_drv = 1'b0;
    logic [31:0] b_ops [2:0];
    logic        b_gnt, b_crv, b_dreq, b_idle;
    logic [31:0] b_dops [2:0];
    logic [5:0]  b_dop;
    logic [14:0] b_dflags;
    logic [2:0]  b_qc;
    logic [2:0]  b_ic;

    apu_req_queue #(.DEPTH(4), .MAX_INFLIGHT(4)) u_dut_mi (
        .clk(clk), .n_reset(n_reset),
        .core_apu_req(b_req), .core_apu_gnt(b_gnt),
        .core_apu_operands(b_ops), .core_apu_op(6'd1), .core_apu_flags_i(15'd0),
        .core_apu_rvalid(b_crv),
        .dec_apu_req(b_dreq), .dec_apu_gnt(b_dgnt),
        .dec_apu_operands(b_dops), .dec_apu_op(b_dop), .dec_apu_flags_i(b_dflags),
        .dec_apu_rvalid(b_drv),
        .queue_count(b_qc), .inflight_count(b_ic), .idle(b_idle)
    );

    int errors = 0;
    int checks = 0;

    // reference model: FIFO contents and in-flight total
    apu_req_entry_t m_q[$];
    int             m_infl = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic apu_req_entry_t dut_head();
        apu_req_entry_t e;
        e.op = dec_op;
        e.flags = dec_flags;
        for (int i = 0; i < 3; i++) e.operands[i] = dec_ops[i];
        return e;
    endfunction

    function automatic apu_req_entry_t drv_entry();
        apu_req_entry_t e;
        e.op = core_op;
        e.flags = core_flags;
        for (int i = 0; i < 3; i++) e.operands[i] = core_ops[i];
        return e;
    endfunction

    task automatic set_entry(input apu_req_entry_t e);
        core_op = e.op;
        core_flags = e.flags;
        for (int i = 0; i < 3; i++) core_ops[i] = e.operands[i];
    endtask

    function automatic apu_req_entry_t rand_entry();
        apu_req_entry_t e;
        for (int i = 0; i < 3; i++) e.operands[i] = $urandom;
        e.op = 6'($urandom);
        e.flags = 15'($urandom);
        return e;
    endfunction

    function automatic bit exp_gnt();
        return (m_q.size() < DEPTH) && (m_infl < MAXI);
    endfunction

    task automatic compare_all();
        check("core_gnt", core_gnt, exp_gnt());
        check("dec_req", dec_req, m_q.size() != 0);
        check("queue_count", qcount, m_q.size());
        check("inflight", icount, m_infl);
        check("idle", idle, m_infl == 0);
        check("core_rvalid", core_rvalid, dec_rvalid);
        if (m_q.size() != 0) check("head_data", dut_head(), m_q[0]);
    endtask

    // one clock: check outputs, advance model with the inputs present at the edge
    task automatic step();
        bit do_push, do_pop;
        #1;
        compare_all();
        do_push = core_req && exp_gnt();
        do_pop  = (m_q.size() != 0) && dec_gnt;
        @(posedge clk);
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(drv_entry());
        m_infl = m_infl + int'(do_push) - int'(dec_rvalid);
        #1;
    endtask

    task automatic drain();
        int budget = 100;
        core_req = 1'b0;
        dec_gnt = 1'b1;
        while (m_infl != 0 && budget > 0) begin
            dec_rvalid = (m_infl > m_q.size());
            step();
            budget--;
        end
        dec_rvalid = 1'b0;
        #1;
        check("drain_idle", icount, 0);
    endtask

    initial begin
        apu_req_entry_t e;
        int k, budget, cyc;
        bit acc;
        for (int i = 0; i < 3; i++) begin core_ops[i] = '0; b_ops[i] = 32'h100 + i; end

        // reset state; rvalid passes straight through even in reset
        dec_rvalid = 1'b1;
        #12;
        check("rst_gnt", core_gnt, 1);
        check("rst_dec_req", dec_req, 0);
        check("rst_qcount", qcount, 0);
        check("rst_icount", icount, 0);
        check("rst_idle", idle, 1);
        check("rst_data", dut_head(), '0);
        check("rst_rvalid_pass", core_rvalid, 1);
        dec_rvalid = 1'b0;
        @(negedge clk) n_reset = 1'b1;
        @(posedge clk); #1;

        // single instruction: visible one cycle later, completed three cycles after pop
        e = '0;
        e.operands[2] = 32'h0220_8057;
        set_entry(e);
        core_req = 1'b1; dec_gnt = 1'b1;
        step();
        core_req = 1'b0;
        check("first_dec_req", dec_req, 1);
        check("first_op2", dec_ops[2], 32'h0220_8057);
        step();
        step();
        step();
        dec_rvalid = 1'b1;
        step();
        dec_rvalid = 1'b0;
        step();
        check("first_idle", idle, 1);

        // five back-to-back with decoder stalled; one pop lets the fifth in
        dec_gnt = 1'b0;
        k = 0; budget = 40; cyc = 0;
        while (k < 5 && budget > 0) begin
            e = rand_entry();
            e.operands[2] = 32'hA000_0000 + k;
            set_entry(e);
            core_req = 1'b1;
            dec_gnt = (cyc == 6);
            acc = exp_gnt();
            step();
            if (acc) k++;
            if (k == 4 && cyc < 6) check("full_gnt_low", core_gnt, 0);
            cyc++;
            budget--;
        end
        check("five_accepted", qcount, 4);
        drain();

        // push and pop together at count 2, wrapping the pointers
        dec_gnt = 1'b0;
        core_req = 1'b1;
        for (int i = 0; i < 2; i++) begin set_entry(rand_entry()); step(); end
        dec_gnt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_entry(rand_entry());
            dec_rvalid = (m_infl > m_q.size());
            step();
            check("pp_count", qcount, 2);
        end
        dec_rvalid = 1'b0;
        drain();

        // random traffic
        for (int i = 0; i < 300; i++) begin
            set_entry(rand_entry());
            core_req = 1'($urandom);
            dec_gnt = ($urandom_range(0, 2) == 0);
            dec_rvalid = (m_infl > m_q.size()) && 1'($urandom);
            step();
        end
        drain();

        // in-flight limit: queue drains but missing completions block the core
        b_req = 1'b1; b_dgnt = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("mi_gnt_low", b_gnt, 0);
        check("mi_qcount", b_qc, 0);
        check("mi_icount", b_ic, 4);
        b_req = 1'b0; b_drv = 1'b1;
        @(posedge clk); #1;
        b_drv = 1'b0;
        check("mi_gnt_back", b_gnt, 1);
        check("mi_icount_dec", b_ic, 3);

        // asynchronous reset with three queued
        dec_gnt = 1'b0; core_req = 1'b1;
        for (int i = 0; i < 3; i++) begin set_entry(rand_entry()); step(); end
        core_req = 1'b0;
        #1;
        check("pre_rst_qcount", qcount, 3);
        n_reset = 1'b0;
        #1;
        check("arst_dec_req", dec_req, 0);
        check("arst_qcount", qcount, 0);
        check("arst_icount", icount, 0);
        check("arst_idle", idle, 1);
        check("arst_gnt", core_gnt, 1);
        check("arst_data", dut_head(), '0);
        m_q.delete();
        m_infl = 0;
        @(negedge clk) n_reset = 1'b1;
        @(posedge clk); #1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
